// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// Optional packet framing is enabled by defining FIFO_RD_LAST_EN.
package fifo_rd_pkg;

  typedef logic [1:0] occ_t;

  localparam int   SKID_DEPTH     = 2;
  localparam occ_t OCC_RESET      = 2'd0;
  localparam logic INFLIGHT_RESET = 1'b0;

  // Buffer occupancy once the pending capture lands and the current transfer leaves.
  function automatic logic [2:0] projected_occ(input occ_t occ, input logic inflight,
                                               input logic xfer);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer holding FIFO words between capture and stream transfer.
// Flush empties the buffer and wins over push and pop in the same cycle.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head_data,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  occ_t                  occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= OCC_RESET;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= OCC_RESET;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rd_ptr];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Converts a registered-read FIFO pop interface into a valid/ready stream.
// Define FIFO_RD_LAST_EN to build the packet counter that drives m_last_o.
//
// Stream handshake: a word moves when m_valid_o && m_ready_i on a rising edge;
// once m_valid_o is high it stays high with m_data_o/m_last_o stable until taken.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  input  logic [LEN_WIDTH-1:0]  pkt_len_i,
  input  logic                  flush_i,
  output logic [1:0]            occupancy_o
);

  logic inflight;
  logic xfer;
  occ_t occ;

  assign m_valid_o   = (occ != OCC_RESET);
  assign xfer        = m_valid_o && m_ready_i;
  assign occupancy_o = occ;

  // Only pop when the word (plus any word already in flight) is sure to fit.
  // rst_n gates the pop so nothing leaves the FIFO while reset is held.
  assign fifo_rd_en_o = rst_n && !fifo_empty_i && !flush_i &&
                        (projected_occ(occ, inflight, xfer) < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= INFLIGHT_RESET;
    else        inflight <= fifo_rd_en_o;
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_rd_data_i),
    .pop       (xfer),
    .flush     (flush_i),
    .head_data (m_data_o),
    .occ       (occ)
  );

`ifdef FIFO_RD_LAST_EN
  logic [LEN_WIDTH-1:0] pkt_cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] len_cur;

  // The first word of a packet sees pkt_len_i live; later words use the latched copy.
  assign len_cur  = (pkt_cnt == '0) ? pkt_len_i : len_q;
  assign m_last_o = m_valid_o && (pkt_cnt == len_cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      len_q   <= '0;
    end else if (flush_i) begin
      pkt_cnt <= '0;
    end else if (xfer) begin
      if (pkt_cnt == '0) len_q <= pkt_len_i;
      if (m_last_o) pkt_cnt <= '0;
      else          pkt_cnt <= pkt_cnt + LEN_WIDTH'(1);
    end
  end
`else
  logic unused_pkt_len;
  assign unused_pkt_len = ^pkt_len_i;
  assign m_last_o       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized bench for fifo_stream_reader against a queue-based stream model.
// Framing checks follow FIFO_RD_LAST_EN when it is defined for the build.
module tb_fifo_stream_reader;

  localparam int DW      = 32;
  localparam int LW      = 8;
  localparam int PKT_LEN = 3;
`ifdef FIFO_RD_LAST_EN
  localparam int EXP_LASTS = 2;
`else
  localparam int EXP_LASTS = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_rd_data_i;
  logic          fifo_rd_en_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          m_last_o;
  logic [LW-1:0] pkt_len_i;
  logic          flush_i;
  logic [1:0]    occupancy_o;

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_last_o       (m_last_o),
    .pkt_len_i      (pkt_len_i),
    .flush_i        (flush_i),
    .occupancy_o    (occupancy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // source FIFO contents and expected stream
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_xfer   = 0;
  int n_last   = 0;
  int word_idx = 0;
  int max_occ  = 0;
  logic saw_throttle = 1'b0;
  logic last_rd      = 1'b0;
  logic stall_prev   = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  task automatic resync_model();
    exp_q      = src_q;
    word_idx   = 0;
    stall_prev = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data",  m_data_o, 32'd0);
    chk("rst_last",  32'(m_last_o), 32'd0);
    chk("rst_occ",   32'(occupancy_o), 32'd0);
  endtask

  // One clock cycle: check the settled outputs, then advance the registered-read FIFO model.
  task automatic tick();
    logic rd;
    logic [DW-1:0] w;
    logic exp_last;
    #1;
    chk("pop_when_empty", 32'(fifo_rd_en_o & fifo_empty_i), 32'd0);
    if (stall_prev) begin
      chk("hold_valid", 32'(m_valid_o), 32'd1);
      chk("hold_data",  m_data_o, prev_data);
      chk("hold_last",  32'(m_last_o), 32'(prev_last));
    end
    if (rst_n && m_valid_o && m_ready_i) begin
      chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("stream_data", m_data_o, w);
      end
`ifdef FIFO_RD_LAST_EN
      exp_last = ((word_idx % (PKT_LEN + 1)) == PKT_LEN);
`else
      exp_last = 1'b0;
`endif
      chk("stream_last", 32'(m_last_o), 32'(exp_last));
      if (m_last_o) n_last++;
      n_xfer++;
      word_idx++;
    end
    if (int'(occupancy_o) > max_occ) max_occ = int'(occupancy_o);
    if (!fifo_rd_en_o && !fifo_empty_i && occupancy_o == 2'd2) saw_throttle = 1'b1;
    stall_prev = rst_n && !flush_i && m_valid_o && !m_ready_i;
    prev_data  = m_data_o;
    prev_last  = m_last_o;
    rd         = fifo_rd_en_o;
    last_rd    = rd;
    @(posedge clk);
    #1;
    if (rd && src_q.size() != 0) fifo_rd_data_i = src_q.pop_front();
    else                         fifo_rd_data_i = $urandom();
    fifo_empty_i = (src_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int xfer_base;
    int pushed;
    rst_n          = 1'b0;
    flush_i        = 1'b0;
    m_ready_i      = 1'b0;
    fifo_empty_i   = 1'b1;
    fifo_rd_data_i = '0;
    pkt_len_i      = LW'(PKT_LEN);
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // three words, ready held high: latency and back-to-back output
    m_ready_i = 1'b1;
    push(32'h11); push(32'h22); push(32'h33);
    #1;
    chk("t1_pop_same_cycle", 32'(fifo_rd_en_o), 32'd1);
    tick();
    chk("t1_valid_n1", 32'(m_valid_o), 32'd0);
    tick();
    chk("t1_valid_n2", 32'(m_valid_o), 32'd1);
    chk("t1_data0", m_data_o, 32'h11);
    tick();
    chk("t1_data1", m_data_o, 32'h22);
    chk("t1_no_pop_empty", 32'(fifo_rd_en_o), 32'd0);
    tick();
    chk("t1_data2", m_data_o, 32'h33);
    tick();
    chk("t1_idle_valid", 32'(m_valid_o), 32'd0);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // 16 words with back-pressure in cycles 3..8
    max_occ = 0;
    saw_throttle = 1'b0;
    xfer_base = n_xfer;
    for (int i = 0; i < 16; i++) push(32'hA000 + 32'(i));
    for (int c = 0; c < 60; c++) begin
      m_ready_i = !(c >= 3 && c <= 8);
      tick();
    end
    chk("bp_max_occ", 32'(max_occ), 32'd2);
    chk("bp_throttle", 32'(saw_throttle), 32'd1);
    chk("bp_count", 32'(n_xfer - xfer_base), 32'd16);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // random ready and random FIFO fill over 1000 words
    xfer_base = n_xfer;
    pushed = 0;
    for (int c = 0; c < 20000; c++) begin
      if (pushed >= 1000 && exp_q.size() == 0) break;
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        push($urandom());
        pushed++;
      end
      m_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready_i = 1'b1;
    run(4);
    chk("rand_count", 32'(n_xfer - xfer_base), 32'd1000);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // flush while one word is buffered and the next is in flight
    m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hF100 + 32'(i));
    run(2);
    chk("fl_pre_occ", 32'(occupancy_o), 32'd1);
    chk("fl_pre_inflight", 32'(last_rd), 32'd1);
    flush_i = 1'b1;
    #1;
    chk("fl_no_pop", 32'(fifo_rd_en_o), 32'd0);
    tick();
    flush_i = 1'b0;
    resync_model();
    chk("fl_occ", 32'(occupancy_o), 32'd0);
    chk("fl_valid", 32'(m_valid_o), 32'd0);
    m_ready_i = 1'b1;
    run(20);
    chk("fl_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in the middle of a burst
    m_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) push(32'hB000 + 32'(i));
    run(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    resync_model();
    run(2);
    rst_n = 1'b1;
    run(30);
    chk("rst_restart_drained", 32'(exp_q.size()), 32'd0);

    // packet framing: pkt_len_i=3 over 8 words from a clean start
    rst_n = 1'b0;
    resync_model();
    run(1);
    rst_n = 1'b1;
    n_last = 0;
    for (int i = 0; i < 8; i++) push(32'hC000 + 32'(i));
    run(20);
    chk("last_count", 32'(n_last), 32'(EXP_LASTS));
    chk("last_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
